lvl_hs_src: RTL and testbench

- Source (initiator) side of a 4-phase REQ/ACK level handshake.
- Converts a single-cycle launch pulse plus a data word into a held REQ level with stable DATA_OUT. Releases only after the far side's ACK, synchronized locally, completes the full 4-phase cycle.
- Counterpart to the destination-side level-to-pulse converter. Used to move UART configuration and data words between clock domains.
- Includes a one-deep pending buffer and a sticky overflow flag.

---
 rtl/lvl_hs_src_pkg.sv | 13 +
 rtl/lvl_hs_src_bit_sync.sv | 24 ++
 rtl/lvl_hs_src.sv | 113 +++++++++++
 tb/tb_lvl_hs_src.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lvl_hs_src_pkg.sv
// Shared definitions for the level-handshake source: FSM encoding and defaults.
package lvl_hs_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ_HI = 2'b01,
    ST_REQ_LO = 2'b10
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_STAGES = 2;

endpackage

// File: rtl/lvl_hs_src_bit_sync.sv
// Multi-flop single-bit synchronizer with synchronous active-high reset.
module lvl_hs_src_bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], d};
    end
  end

  assign q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/lvl_hs_src.sv
// Source side of a 4-phase REQ/ACK level handshake with a one-deep pending
// buffer and sticky overflow flag.
//
// Handshake: REQ rises with DATA_OUT already stable; the far side raises ACK
// once it has taken the word; REQ then falls; the far side drops ACK; only
// then is the cycle complete (DONE) and a new word may be launched. All
// decisions use the locally synchronized ack_s, never the raw ACK.
module lvl_hs_src
  import lvl_hs_src_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PULSE_IN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  ACK,
  input  logic                  OVF_CLR,
  output logic                  REQ,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF
);

  state_t                  state;
  state_t                  state_n;
  logic                    ack_s;
  logic                    pend_vld;
  logic [DATA_WIDTH-1:0]   pend_data;

  logic                    launch_ok;
  logic                    launch;
  logic [DATA_WIDTH-1:0]   launch_data;
  logic                    pulse_direct;
  logic                    pend_take;
  logic                    pulse_store;
  logic                    pulse_drop;

  lvl_hs_src_bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .clk(CLK),
    .rst(RST),
    .d  (ACK),
    .q  (ack_s)
  );

  // Launch arbitration, pending-buffer bookkeeping and next-state selection.
  always_comb begin
    launch_ok    = 1'b0;
    launch       = 1'b0;
    launch_data  = DATA_IN;
    pulse_direct = 1'b0;
    pend_take    = 1'b0;
    pulse_store  = 1'b0;
    pulse_drop   = 1'b0;
    state_n      = state;

    // A launch is allowed from IDLE, or straight out of a completing REQ_LO,
    // and only while the synchronized ACK is low (a stale ACK holds it off).
    launch_ok    = !ack_s && ((state == ST_IDLE) || (state == ST_REQ_LO));
    launch       = launch_ok && (pend_vld || PULSE_IN);
    launch_data  = pend_vld ? pend_data : DATA_IN;
    // Pending word wins; a simultaneous pulse then refills the buffer.
    pulse_direct = launch && !pend_vld;
    pend_take    = launch && pend_vld;
    pulse_store  = PULSE_IN && !pulse_direct && (!pend_vld || pend_take);
    pulse_drop   = PULSE_IN && !pulse_direct && pend_vld && !pend_take;

    case (state)
      ST_IDLE: begin
        if (launch) state_n = ST_REQ_HI;
      end
      ST_REQ_HI: begin
        if (ack_s) state_n = ST_REQ_LO;
      end
      ST_REQ_LO: begin
        if (!ack_s) state_n = launch ? ST_REQ_HI : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, REQ level, output word, pending buffer and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      REQ       <= 1'b0;
      DATA_OUT  <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      OVF       <= 1'b0;
    end else begin
      state    <= state_n;
      REQ      <= (state_n == ST_REQ_HI);
      if (launch) DATA_OUT <= launch_data;
      pend_vld <= (pend_vld && !pend_take) || pulse_store;
      if (pulse_store) pend_data <= DATA_IN;
      // Set has priority over clear so no drop event is ever lost.
      if (pulse_drop) begin
        OVF <= 1'b1;
      end else if (OVF_CLR) begin
        OVF <= 1'b0;
      end
    end
  end

  assign DONE = (state == ST_REQ_LO) && !ack_s;
  assign BUSY = (state != ST_IDLE) || pend_vld;

endmodule

// File: tb/tb_lvl_hs_src.sv
// Directed bench for lvl_hs_src with a delayed ACK loop model and scoreboard.
module tb_lvl_hs_src;

  localparam int DW = 8;
  localparam int NS = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          PULSE_IN;
  logic [DW-1:0] DATA_IN;
  logic          OVF_CLR;
  wire           ACK;
  logic          REQ;
  logic [DW-1:0] DATA_OUT;
  logic          BUSY;
  logic          DONE;
  logic          OVF;

  logic          ack_loop  = 1'b0;
  logic          ack_force = 1'b0;
  logic [2:0]    ack_dly   = 3'b000;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic req_prev = 1'b0;
  logic [DW-1:0] exp_q[$];

  lvl_hs_src #(
    .DATA_WIDTH(DW),
    .NUM_STAGES(NS)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .PULSE_IN(PULSE_IN),
    .DATA_IN (DATA_IN),
    .ACK     (ACK),
    .OVF_CLR (OVF_CLR),
    .REQ     (REQ),
    .DATA_OUT(DATA_OUT),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVF     (OVF)
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // Far-side model: ACK mirrors REQ three cycles late, or is forced.
  always @(posedge CLK) ack_dly <= {ack_dly[1:0], REQ};
  assign ACK = ack_loop ? ack_dly[2] : ack_force;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every REQ rising edge must present the next expected word
  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
    if (REQ === 1'b1 && req_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_launch", 32'(exp_q.size()), 32'd1);
      end else begin
        check("launch_word", 32'(DATA_OUT), 32'(exp_q.pop_front()));
      end
    end
    req_prev = REQ;
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    PULSE_IN = 1'b1;
    DATA_IN  = d;
    tick();
    PULSE_IN = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!DONE && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(DONE), 32'd1);
  endtask

  initial begin
    int cyc;
    int ack_rise;
    int req_fall;
    int d0;

    RST = 1'b1; PULSE_IN = 1'b0; DATA_IN = '0; OVF_CLR = 1'b0;
    repeat (3) tick();
    check("rst_req",  32'(REQ), 32'd0);
    check("rst_data", 32'(DATA_OUT), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_ovf",  32'(OVF), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    ack_loop = 1'b1;
    repeat (4) tick();

    // single transfer
    d0 = done_cnt;
    exp_q.push_back(8'hA5);
    pulse(8'hA5);
    check("t1_req_up",  32'(REQ), 32'd1);
    check("t1_data",    32'(DATA_OUT), 32'hA5);
    check("t1_busy",    32'(BUSY), 32'd1);
    cyc = 0; ack_rise = -1; req_fall = -1;
    while (!DONE && cyc < 40) begin
      tick();
      cyc++;
      if (ACK && ack_rise < 0) ack_rise = cyc;
      if (!REQ && req_fall < 0) req_fall = cyc;
      check("t1_hold", 32'(DATA_OUT), 32'hA5);
    end
    check("t1_done_seen",  32'(DONE), 32'd1);
    check("t1_done_cycle", 32'(cyc), 32'd11);
    check("t1_req_fall",   32'(req_fall - ack_rise), 32'(NS + 1));
    tick();
    check("t1_done_one",   32'(DONE), 32'd0);
    check("t1_busy_end",   32'(BUSY), 32'd0);
    check("t1_done_cnt",   32'(done_cnt - d0), 32'd1);

    // back-to-back with pending chain
    d0 = done_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    pulse(8'h11);
    tick();
    pulse(8'h22);
    check("t2_busy",  32'(BUSY), 32'd1);
    check("t2_req",   32'(REQ), 32'd1);
    check("t2_data",  32'(DATA_OUT), 32'h11);
    wait_done("t2_done1");
    check("t2_busy_done", 32'(BUSY), 32'd1);
    tick();
    check("t2_chain_req",  32'(REQ), 32'd1);
    check("t2_chain_data", 32'(DATA_OUT), 32'h22);
    wait_done("t2_done2");
    tick();
    check("t2_busy_end", 32'(BUSY), 32'd0);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd2);

    // overflow
    ack_loop = 1'b0; ack_force = 1'b0;
    d0 = done_cnt;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    pulse(8'h01);
    pulse(8'h02);
    check("t3_no_ovf", 32'(OVF), 32'd0);
    pulse(8'h03);
    check("t3_ovf",    32'(OVF), 32'd1);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    check("t3_ovf_clr", 32'(OVF), 32'd0);
    OVF_CLR = 1'b1;
    pulse(8'h04);
    OVF_CLR = 1'b0;
    check("t3_set_wins", 32'(OVF), 32'd1);
    check("t3_data",     32'(DATA_OUT), 32'h01);
    ack_loop = 1'b1;
    wait_done("t3_done1");
    tick();
    check("t3_chain_data", 32'(DATA_OUT), 32'h02);
    wait_done("t3_done2");
    tick();
    check("t3_busy_end", 32'(BUSY), 32'd0);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd2);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    check("t3_ovf_end", 32'(OVF), 32'd0);

    // stale ACK
    ack_loop = 1'b0; ack_force = 1'b1;
    repeat (NS + 2) tick();
    exp_q.push_back(8'h5A);
    pulse(8'h5A);
    check("t4_req_held", 32'(REQ), 32'd0);
    check("t4_busy",     32'(BUSY), 32'd1);
    repeat (3) begin
      tick();
      check("t4_req_hold", 32'(REQ), 32'd0);
    end
    ack_force = 1'b0;
    tick();
    check("t4_req_a", 32'(REQ), 32'd0);
    tick();
    check("t4_req_b", 32'(REQ), 32'd0);
    tick();
    check("t4_req_up",  32'(REQ), 32'd1);
    check("t4_data",    32'(DATA_OUT), 32'h5A);
    ack_loop = 1'b1;
    wait_done("t4_done");
    tick();
    check("t4_busy_end", 32'(BUSY), 32'd0);

    // reset mid-transfer
    ack_loop = 1'b0; ack_force = 1'b0;
    d0 = done_cnt;
    exp_q.push_back(8'h33);
    pulse(8'h33);
    pulse(8'h44);
    pulse(8'h55);
    check("t5_ovf_pre", 32'(OVF), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t5_req",  32'(REQ), 32'd0);
    check("t5_data", 32'(DATA_OUT), 32'd0);
    check("t5_busy", 32'(BUSY), 32'd0);
    check("t5_ovf",  32'(OVF), 32'd0);
    repeat (8) begin
      tick();
      check("t5_quiet_req", 32'(REQ), 32'd0);
    end
    check("t5_no_done",  32'(done_cnt - d0), 32'd0);
    check("t5_busy_end", 32'(BUSY), 32'd0);

    // completion plus pulse in the DONE cycle
    ack_loop = 1'b1;
    d0 = done_cnt;
    exp_q.push_back(8'h66);
    pulse(8'h66);
    wait_done("t6_done1");
    exp_q.push_back(8'h77);
    pulse(8'h77);
    check("t6_req",  32'(REQ), 32'd1);
    check("t6_data", 32'(DATA_OUT), 32'h77);
    check("t6_busy", 32'(BUSY), 32'd1);
    wait_done("t6_done2");
    tick();
    check("t6_busy_end", 32'(BUSY), 32'd0);
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd2);

    repeat (2) tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
